// File: rtl/tile_shuffle_ctrl.sv
// -----------------------------------------------------------------------------
// tile_shuffle_ctrl
//
// Builds a uniform random permutation of N_TILES picture indices, one for each
// board position, at the start of a game. A Fisher-Yates shuffle runs in place
// over an internal position array. A free-running Galois LFSR supplies the
// randomness, and game/display logic reads the result through a registered
// read port.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      one-cycle shuffle request, honoured only in IDLE
//   seed_load  load seed_in into the LFSR, honoured only in IDLE
//   seed_in    LFSR seed value (zero is replaced by SEED)
//   busy       high from the cycle after an accepted start until DONE
//   done       one-cycle pulse when the shuffle completes
//   rd_addr    board position to read
//   rd_data    tile index at rd_addr, one cycle later (0 when out of range)
// -----------------------------------------------------------------------------
module tile_shuffle_ctrl #(
    parameter int                N_TILES = 24,
    parameter int                IDX_W   = 6,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              done,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [IDX_W-1:0]  rd_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_DRAW = 3'd2,
        S_SWAP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [LFSR_W-1:0] TAPS    = 16'hB400;
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(N_TILES - 1);
    localparam logic [IDX_W-1:0]  ONE_IDX = IDX_W'(1);

    // Smallest 2^k-1 that is >= v: smear the highest set bit downwards.
    function automatic logic [IDX_W-1:0] mask_of(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int s = 1; s < IDX_W; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    // One Galois LFSR step.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        logic [LFSR_W-1:0] n;
        if (l[0]) begin
            n = (l >> 1) ^ TAPS;
        end else begin
            n = l >> 1;
        end
        return n;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [LFSR_W-1:0] lfsr_r;
    logic [IDX_W-1:0]  idx_i_r;
    logic [IDX_W-1:0]  idx_j_r;
    logic [IDX_W-1:0]  tile_r [N_TILES];
    logic              busy_r;
    logic              done_r;
    logic [IDX_W-1:0]  rd_data_r;

    logic [IDX_W-1:0]  cand_s;
    logic              accept_s;
    logic [IDX_W-1:0]  tile_i_s;
    logic [IDX_W-1:0]  tile_j_s;
    logic [IDX_W-1:0]  rd_val_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_data = rd_data_r;

    // Draw candidate: masked LFSR bits, rejected when above the current index.
    always_comb begin
        cand_s   = lfsr_r[IDX_W-1:0] & mask_of(idx_i_r);
        accept_s = (cand_s <= idx_i_r);
    end

    // Array read muxes for the swap pair and the external read port.
    always_comb begin
        tile_i_s = {IDX_W{1'b0}};
        tile_j_s = {IDX_W{1'b0}};
        rd_val_s = {IDX_W{1'b0}};
        for (int k = 0; k < N_TILES; k++) begin
            if (idx_i_r == IDX_W'(k)) begin
                tile_i_s = tile_r[k];
            end else begin
                tile_i_s = tile_i_s;
            end
            if (idx_j_r == IDX_W'(k)) begin
                tile_j_s = tile_r[k];
            end else begin
                tile_j_s = tile_j_s;
            end
            if (rd_addr == IDX_W'(k)) begin
                rd_val_s = tile_r[k];
            end else begin
                rd_val_s = rd_val_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_INIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT: begin
                if (idx_i_r == LAST) begin
                    state_s = S_DRAW;
                end else begin
                    state_s = S_INIT;
                end
            end
            S_DRAW: begin
                if (accept_s) begin
                    state_s = S_SWAP;
                end else begin
                    state_s = S_DRAW;
                end
            end
            S_SWAP: begin
                if (idx_i_r == ONE_IDX) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAW;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // LFSR: free-running; a seed load in IDLE overrides the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else if ((state_r == S_IDLE) && seed_load) begin
            lfsr_r <= (seed_in == {LFSR_W{1'b0}}) ? SEED : seed_in;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Shuffle indices and the registered busy/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_i_r <= {IDX_W{1'b0}};
            idx_j_r <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        idx_i_r <= {IDX_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_INIT: begin
                    // Leaves INIT already pointing at the top position.
                    if (idx_i_r == LAST) begin
                        idx_i_r <= LAST;
                    end else begin
                        idx_i_r <= idx_i_r + ONE_IDX;
                    end
                end
                S_DRAW: begin
                    if (accept_s) begin
                        idx_j_r <= cand_s;
                    end else begin
                        idx_j_r <= idx_j_r;
                    end
                end
                S_SWAP: begin
                    // busy drops as done rises so they are never high together.
                    if (idx_i_r == ONE_IDX) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        idx_i_r <= idx_i_r - ONE_IDX;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Position array: identity on reset, filled in INIT, exchanged in SWAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TILES; k++) begin
                tile_r[k] <= IDX_W'(k);
            end
        end else begin
            for (int k = 0; k < N_TILES; k++) begin
                if ((state_r == S_INIT) && (idx_i_r == IDX_W'(k))) begin
                    tile_r[k] <= IDX_W'(k);
                end else if ((state_r == S_SWAP) && (idx_i_r == IDX_W'(k))) begin
                    tile_r[k] <= tile_j_s;
                end else if ((state_r == S_SWAP) && (idx_j_r == IDX_W'(k))) begin
                    tile_r[k] <= tile_i_s;
                end else begin
                    tile_r[k] <= tile_r[k];
                end
            end
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {IDX_W{1'b0}};
        end else begin
            rd_data_r <= rd_val_s;
        end
    end

endmodule

// File: tb/tb_tile_shuffle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tile_shuffle_ctrl
//
// Self-checking bench for tile_shuffle_ctrl. A reference model of the LFSR and
// the Fisher-Yates sequence predicts, for each run, the final permutation and
// the cycle at which done appears. Read results go through a queue-based
// scoreboard.
// -----------------------------------------------------------------------------
module tb_tile_shuffle_ctrl;

    localparam int N     = 24;
    localparam int LIMIT = 3000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        busy;
    logic        done;
    logic [5:0]  rd_addr;
    logic [5:0]  rd_data;

    int n_vec;
    int n_err;
    int exp_q [$];
    int exp_perm [N];
    int exp_cnt;
    logic [5:0] got_perm [N];
    int got_cnt;
    logic [5:0] res_a [N];
    logic [5:0] res_b [N];
    int cnt_a;

    tile_shuffle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] adv(input logic [15:0] l);
        if (l[0]) return (l >> 1) ^ 16'hB400;
        else      return l >> 1;
    endfunction

    // Reference model: seed loaded at edge L, start accepted at edge L+d.
    task automatic model_run(input logic [15:0] s, input int d);
        logic [15:0] l;
        int m, r, n, t;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int k = 0; k < d + N; k++) l = adv(l);
        for (int k = 0; k < N; k++) exp_perm[k] = k;
        n = 0;
        for (int i = N - 1; i >= 1; i--) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            r = int'(l[5:0]) & m;
            l = adv(l);
            n++;
            while (r > i) begin
                r = int'(l[5:0]) & m;
                l = adv(l);
                n++;
            end
            t = exp_perm[i];
            exp_perm[i] = exp_perm[r];
            exp_perm[r] = t;
            l = adv(l);
            n++;
        end
        exp_cnt = N + 1 + n;
    endtask

    // Drive a read address, queue the expectation, compare on the next cycle.
    task automatic read_check(input int a, input int e, output logic [5:0] v);
        int want;
        rd_addr = a[5:0];
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        v = rd_data;
        n_vec++;
        if (rd_data !== want[5:0]) begin
            n_err++;
            $display("FAIL read addr=%0d: got %0d, expected %0d", a, rd_data, want);
        end
    endtask

    // Seed load, start d cycles later, wait for done, check timing and result.
    task automatic run_shuffle(input logic [15:0] s, input int d, input bit second);
        int cnt, extra;
        logic [5:0] v;
        logic [N-1:0] seen;
        model_run(s, d);
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = s;
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0;
        repeat (d - 1) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b, expected 1", busy);
        end
        cnt = 1;
        while (done !== 1'b1 && cnt < LIMIT) begin
            start = (second && cnt == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        got_cnt = cnt;
        n_vec++;
        if (cnt != exp_cnt || done !== 1'b1) begin
            n_err++;
            $display("FAIL done_latency: got %0d cycles (done=%b), expected %0d", cnt, done, exp_cnt);
        end
        n_vec++;
        if (busy !== 1'b0 || cnt < 71) begin
            n_err++;
            $display("FAIL busy_at_done: got busy=%b cnt=%0d, expected busy=0 cnt>=71", busy, cnt);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL done_single_pulse: got %0d extra pulses, expected 0", extra);
        end
        seen = '0;
        for (int a = 0; a < N; a++) begin
            read_check(a, exp_perm[a], v);
            got_perm[a] = v;
            if (v < 6'(N)) seen[v] = 1'b1;
        end
        n_vec++;
        if (seen !== {N{1'b1}}) begin
            n_err++;
            $display("FAIL permutation_cover: got coverage %h, expected %h", seen, {N{1'b1}});
        end
    endtask

    task automatic test_reset;
        logic [5:0] v;
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = 16'h0; rd_addr = 6'd0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 6'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b rd=%0d, expected 0 0 0", busy, done, rd_data);
        end
        rst = 1'b0;
        read_check(0, 0, v);
        read_check(5, 5, v);
        read_check(23, 23, v);
        read_check(30, 0, v);
    endtask

    task automatic test_shuffle;
        run_shuffle(16'h1234, 3, 1'b0);
        res_a = got_perm;
        cnt_a = got_cnt;
    endtask

    task automatic test_repeat;
        bit same;
        run_shuffle(16'h1234, 3, 1'b0);
        same = 1'b1;
        for (int k = 0; k < N; k++) if (got_perm[k] !== res_a[k]) same = 1'b0;
        n_vec++;
        if (!same) begin
            n_err++;
            $display("FAIL repeat_identical: got differing result, expected identical");
        end
        run_shuffle(16'h4321, 3, 1'b0);
        same = 1'b1;
        for (int k = 0; k < N; k++) if (got_perm[k] !== res_a[k]) same = 1'b0;
        n_vec++;
        if (same) begin
            n_err++;
            $display("FAIL other_seed_differs: got identical result, expected a different one");
        end
    endtask

    task automatic test_zero_seed;
        bit same;
        run_shuffle(16'hACE1, 5, 1'b0);
        res_b = got_perm;
        run_shuffle(16'h0000, 5, 1'b0);
        same = 1'b1;
        for (int k = 0; k < N; k++) if (got_perm[k] !== res_b[k]) same = 1'b0;
        n_vec++;
        if (!same) begin
            n_err++;
            $display("FAIL zero_seed: got result unlike SEED run, expected identical");
        end
    endtask

    task automatic test_double_start;
        run_shuffle(16'h1234, 3, 1'b1);
        n_vec++;
        if (got_cnt != cnt_a) begin
            n_err++;
            $display("FAIL double_start_cycles: got %0d, expected %0d", got_cnt, cnt_a);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] v;
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (N) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_abort: got %b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b done=%b, expected 0 0", busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        read_check(7, 7, v);
        read_check(23, 23, v);
        run_shuffle(16'h5A5A, 2, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_shuffle();
        test_repeat();
        test_zero_seed();
        test_double_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_shuffle_ctrl.md
Name: tile_shuffle_ctrl

Overview:
- Builds a fresh random tile layout for the Chicken Cha Cha Cha board at the start of each game: a uniform random permutation of N_TILES picture indices, one per board position.
- Sequences an in-place Fisher-Yates shuffle over an internal position array, driven by a free-running LFSR.
- Game/display logic reads the result through a registered read port.
- Replaces a fixed table of precomputed orders with an on-chip generator.

Parameters:
- N_TILES, 24, number of board positions / picture indices.
- IDX_W, 6, width of one tile index and of the read address.
- LFSR_W, 16, LFSR width.
- SEED, 16'hACE1, LFSR reset value and substitute for a zero seed load.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to shuffle; honoured only in IDLE.
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE.
- seed_in  in  LFSR_W  seed value.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when the shuffle completes.
- rd_addr  in  IDX_W  board position to read.
- rd_data  out  IDX_W  tile index at rd_addr, registered.

Behaviour:
- Reset (async): state=IDLE; busy=0; done=0; rd_data=0; lfsr=SEED; array tile[k]=k for all k.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (toggle mask 16'hB400). Advances every cycle in every state, so start timing adds entropy. Never zero.
- seed_load in IDLE: lfsr<=seed_in, or SEED if seed_in==0. Takes priority over advance that cycle. If start and seed_load are asserted in the same cycle, the seed is loaded and start is accepted; the shuffle uses the loaded seed.
- FSM states: IDLE, INIT, DRAW, SWAP, DONE.
  - IDLE: start -> INIT, i<=0, busy<=1.
  - INIT: tile[i]<=i, one entry per cycle. After i==N_TILES-1 -> DRAW with i<=N_TILES-1. Takes exactly N_TILES cycles.
  - DRAW: candidate r = lfsr[IDX_W-1:0] & mask(i), where mask(i) is the smallest 2^k-1 >= i. Accept if r<=i and go to SWAP with j<=r. Otherwise stay and retry next cycle (the LFSR has advanced).
  - SWAP: tile[i]<=tile[j] and tile[j]<=tile[i] in one cycle; r==i is a legal no-op swap. If i==1 -> DONE, else i<=i-1 -> DRAW.
  - DONE: done=1 for exactly one cycle, busy<=0, -> IDLE.
- Latency: minimum N_TILES + 2*(N_TILES-1) + 1 cycles from the accepted start to the done pulse (71 for the default). Maximum is unbounded in principle but bounded in practice by the LFSR period.
- start while busy (INIT/DRAW/SWAP/DONE): ignored, not queued.
- seed_load while busy: ignored.
- Read port: rd_data <= tile[rd_addr] on every clock, 1-cycle latency.
  - rd_addr >= N_TILES returns 0.
  - Reads during busy return current in-flux contents; consumers sample only after done.
- Async reset mid-operation: immediate return to reset state; array restored to identity; no done pulse.
- Invariant: after every SWAP and after DONE, the array is a permutation of 0..N_TILES-1.

Test Plan:
- Reset, then read addresses 0, 5, 23, 30 -> rd_data 0, 5, 23, 0 one cycle after each address; busy=0, done=0.
- seed_load with seed_in=16'h1234, then start -> busy rises next cycle; done pulses once after >=71 cycles; busy=0 with done; all 24 reads return distinct values covering 0..23 exactly.
- Repeat the previous scenario with the identical seed and start cycle offset -> identical 24-entry result. With seed_in=16'h4321 -> a different result.
- seed_load with seed_in=0 -> behaves identically to seed_load with SEED=16'hACE1.
- Pulse start again 10 cycles after the first start -> ignored; exactly one done pulse; cycle count identical to a single-start run.
- Assert rst during DRAW -> busy=0 and done=0 immediately; reads return identity (addr 7 -> 7); a subsequent start runs to completion normally.
